// File: rtl/ball_pkg.sv
// Shared types and constants for the multi-ball motion engine.
// Latency: none (constants, state enum and a combinational keycode decoder).
// Backpressure: not applicable.
package ball_pkg;

    // USB HID keycodes for the four direction keys
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    // Default 640x480 playfield edges
    localparam int DEF_X_MIN = 0;
    localparam int DEF_X_MAX = 639;
    localparam int DEF_Y_MIN = 0;
    localparam int DEF_Y_MAX = 479;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } engine_state_t;

    // Direction requested by a key: dx/dy are -1, 0 or +1 (two's complement)
    typedef struct packed {
        logic              valid;
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } key_dir_t;

    // Map a keycode onto per-axis direction; a direction key zeroes the other axis
    function automatic key_dir_t decode_key(input logic [7:0] code);
        key_dir_t kd;
        kd = '0;
        case (code)
            KEY_A: begin kd.valid = 1'b1; kd.dx = 2'b11; end
            KEY_D: begin kd.valid = 1'b1; kd.dx = 2'b01; end
            KEY_W: begin kd.valid = 1'b1; kd.dy = 2'b11; end
            KEY_S: begin kd.valid = 1'b1; kd.dy = 2'b01; end
            default: kd = '0;
        endcase
        return kd;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis motion step: next velocity and next position for a single ball coordinate.
// Latency: purely combinational, result usable in the same cycle.
// Backpressure: none; the caller decides when to commit the result.
// BALL_ENGINE_WRAP_EN selects wrap-around at the edges instead of bouncing.
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int BALL_SIZE = 4,
    parameter int STEP      = 1
) (
    input  logic [COORD_W-1:0]        pos,
    input  logic signed [COORD_W-1:0] vel,
    input  logic [COORD_W-1:0]        min,
    input  logic [COORD_W-1:0]        max,
    input  logic signed [1:0]         key_dir,
    input  logic                      key_valid,
    output logic [COORD_W-1:0]        pos_next,
    output logic signed [COORD_W-1:0] vel_next
);

    localparam int EW = COORD_W + 1;
    localparam logic signed [COORD_W-1:0] VEL_POS = COORD_W'(STEP);
    localparam logic signed [COORD_W-1:0] VEL_NEG = COORD_W'(-STEP);

    logic signed [COORD_W-1:0] key_vel;

    // Translate the key's direction into a velocity on this axis
    always_comb begin
        key_vel = '0;
        case (key_dir)
            2'b01:   key_vel = VEL_POS;
            2'b11:   key_vel = VEL_NEG;
            default: key_vel = '0;
        endcase
    end

`ifdef BALL_ENGINE_WRAP_EN
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] lim_lo;
    logic signed [EW-1:0] lim_hi;

    // Velocity only changes by key; a position leaving the window reappears on the far side
    always_comb begin
        vel_next = key_valid ? key_vel : vel;
        sum      = $signed({1'b0, pos}) + $signed({vel_next[COORD_W-1], vel_next});
        lim_lo   = $signed({1'b0, min}) + $signed(EW'(BALL_SIZE));
        lim_hi   = $signed({1'b0, max}) - $signed(EW'(BALL_SIZE));
        if (sum > lim_hi) begin
            pos_next = lim_lo[COORD_W-1:0];
        end else if (sum < lim_lo) begin
            pos_next = lim_hi[COORD_W-1:0];
        end else begin
            pos_next = sum[COORD_W-1:0];
        end
    end
`else
    logic hit_hi;
    logic hit_lo;

    // Edge bounce wins over the key, the key wins over the held velocity
    always_comb begin
        // One extra bit so pos + BALL_SIZE cannot wrap near the top of the range
        hit_hi = ({1'b0, pos} + EW'(BALL_SIZE)) >= {1'b0, max};
        hit_lo = {1'b0, pos} <= ({1'b0, min} + EW'(BALL_SIZE));
        if (hit_hi) begin
            vel_next = VEL_NEG;
        end else if (hit_lo) begin
            vel_next = VEL_POS;
        end else if (key_valid) begin
            vel_next = key_vel;
        end else begin
            vel_next = vel;
        end
        pos_next = pos + $unsigned(vel_next);
    end
`endif

endmodule

// File: rtl/ball_engine.sv
// N-ball motion engine: once per VGA frame, steps every ball (one per cycle); ball `sel` follows the keyboard.
// Latency: frame_tick 3 cycles after vs falls; frame_done NUM_BALLS+1 cycles after frame_tick.
// Backpressure: none; a frame edge arriving while busy is dropped and flagged on sticky overrun.
// BALL_ENGINE_WRAP_EN: when defined, balls wrap around the playfield instead of bouncing.
module ball_engine
    import ball_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int COORD_W   = 10,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MIN     = DEF_Y_MIN,
    parameter int Y_MAX     = DEF_Y_MAX,
    parameter int BALL_SIZE = 4,
    parameter int STEP      = 1,
    parameter int X_INIT    = 64,
    parameter int SPACING   = 64,
    parameter int Y_INIT    = 240
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           vs,
    input  logic [7:0]                     keycode,
    input  logic [$clog2(NUM_BALLS)-1:0]   sel,
    output logic [NUM_BALLS*COORD_W-1:0]   BallX,
    output logic [NUM_BALLS*COORD_W-1:0]   BallY,
    output logic [COORD_W-1:0]             BallS,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);

    localparam int SEL_W = $clog2(NUM_BALLS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_BALLS - 1);

    // vs synchroniser and edge detector; idle level of vs is high
    logic vs_s1, vs_s2, vs_s3;
    logic frame_tick;

    engine_state_t state, state_nxt;
    logic          start;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] sel_q;
    logic [7:0]       key_q;

    logic [COORD_W-1:0]        pos_x [NUM_BALLS];
    logic [COORD_W-1:0]        pos_y [NUM_BALLS];
    logic signed [COORD_W-1:0] vel_x [NUM_BALLS];
    logic signed [COORD_W-1:0] vel_y [NUM_BALLS];

    key_dir_t                  kd;
    logic                      ctrl;
    logic [COORD_W-1:0]        nx_pos, ny_pos;
    logic signed [COORD_W-1:0] nx_vel, ny_vel;

    // Two-flop synchroniser, a history flop, and a registered falling-edge pulse
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_s1      <= 1'b1;
            vs_s2      <= 1'b1;
            vs_s3      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_s1      <= vs;
            vs_s2      <= vs_s1;
            vs_s3      <= vs_s2;
            frame_tick <= vs_s3 & ~vs_s2;
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and Moore outputs
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_nxt = UPDATE;
                    start     = 1'b1;
                end
            end
            UPDATE: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame-start capture of the controls, and the ball index walk
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx   <= '0;
            sel_q <= '0;
            key_q <= '0;
        end else if (start) begin
            idx   <= '0;
            sel_q <= sel;
            key_q <= keycode;
        end else if (state == UPDATE) begin
            idx <= idx + SEL_W'(1);
        end
    end

    // Sticky flag: a frame edge the engine could not take
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            overrun <= 1'b0;
        end else if (frame_tick && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Only the selected ball sees the key; an out-of-range sel never matches idx
    always_comb begin
        kd   = decode_key(key_q);
        ctrl = (idx == sel_q) && kd.valid;
    end

    ball_axis_step #(
        .COORD_W   (COORD_W),
        .BALL_SIZE (BALL_SIZE),
        .STEP      (STEP)
    ) u_step_x (
        .pos       (pos_x[idx]),
        .vel       (vel_x[idx]),
        .min       (COORD_W'(X_MIN)),
        .max       (COORD_W'(X_MAX)),
        .key_dir   (kd.dx),
        .key_valid (ctrl),
        .pos_next  (nx_pos),
        .vel_next  (nx_vel)
    );

    ball_axis_step #(
        .COORD_W   (COORD_W),
        .BALL_SIZE (BALL_SIZE),
        .STEP      (STEP)
    ) u_step_y (
        .pos       (pos_y[idx]),
        .vel       (vel_y[idx]),
        .min       (COORD_W'(Y_MIN)),
        .max       (COORD_W'(Y_MAX)),
        .key_dir   (kd.dy),
        .key_valid (ctrl),
        .pos_next  (ny_pos),
        .vel_next  (ny_vel)
    );

    // Ball state: reset formation, then one ball rewritten per UPDATE cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                pos_x[i] <= COORD_W'(X_INIT + i * SPACING);
                pos_y[i] <= COORD_W'(Y_INIT);
                vel_x[i] <= '0;
                vel_y[i] <= COORD_W'(STEP);
            end
        end else if (state == UPDATE) begin
            pos_x[idx] <= nx_pos;
            pos_y[idx] <= ny_pos;
            vel_x[idx] <= nx_vel;
            vel_y[idx] <= ny_vel;
        end
    end

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_pack
        assign BallX[g*COORD_W +: COORD_W] = pos_x[g];
        assign BallY[g*COORD_W +: COORD_W] = pos_y[g];
    end

    assign BallS = COORD_W'(BALL_SIZE);

endmodule
